// File: rtl/channel_seq_pkg.sv
// Shared definitions for the tracker channel sequencer.
//   - seq_state_t : sequencer FSM states
//   - row field bit positions for the 32-bit pattern row
//   - note / effect / volume constants
//   - BASE_FCW    : octave-7 phase increments, 32-bit phase, 50 MHz system clock
package channel_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_APPLY = 2'd2,
    ST_RUN   = 2'd3
  } seq_state_t;

  localparam int NOTE_MSB      = 31;
  localparam int NOTE_LSB      = 24;
  localparam int VOL_VALID_BIT = 23;
  localparam int VOLUME_MSB    = 21;
  localparam int VOLUME_LSB    = 16;
  localparam int EFFECT_MSB    = 15;
  localparam int EFFECT_LSB    = 8;
  localparam int PARAM_MSB     = 7;
  localparam int PARAM_LSB     = 0;

  localparam logic [7:0] NOTE_OFF      = 8'hFF;
  localparam logic [7:0] NOTE_MAX      = 8'd96;
  localparam logic [7:0] EFF_VOL_SLIDE = 8'h0A;
  localparam logic [5:0] VOL_MAX       = 6'd63;

  // C7 .. B7, fcw = f * 2^32 / 50 MHz
  localparam logic [31:0] BASE_FCW [12] = '{
    32'd179788, 32'd190478, 32'd201805, 32'd213805,
    32'd226518, 32'd239988, 32'd254258, 32'd269377,
    32'd285395, 32'd302366, 32'd320345, 32'd339394
  };

endpackage

// File: rtl/channel_sequencer_note_to_fcw.sv
// Combinational note-number to DDS frequency-word lookup.
//   note : tracker note, 1..96 valid (1 = C0, 96 = B7)
//   fcw  : phase increment; 0 for any out-of-range note
module note_to_fcw #(
  parameter int PHASE_WIDTH = 32
) (
  input  logic [7:0]             note,
  output logic [PHASE_WIDTH-1:0] fcw
);
  import channel_seq_pkg::*;

  logic [7:0]  n;
  logic [3:0]  oct;
  logic [3:0]  semi;
  logic [31:0] base;

  // Lower octaves are the octave-7 table halved once per octave down.
  always_comb begin
    n    = note - 8'd1;
    oct  = 4'(n / 8'd12);
    semi = 4'(n % 8'd12);
    base = BASE_FCW[semi];
    fcw  = '0;
    if (note != 8'd0 && note <= NOTE_MAX)
      fcw = PHASE_WIDTH'(base >> (4'd7 - oct));
  end

endmodule

// File: rtl/channel_sequencer.sv
// Tracker row sequencer for one DDS voice.
// Fetches a pattern row over a req/valid handshake, decodes note/volume/effect,
// drives freq_word/vol, and advances rows every `speed` tracker ticks.
//   clk, rst_active_low        : clock, async active-low reset
//   start, stop                : play from row 0 / halt and mute (stop wins)
//   tick_strobe                : tracker tick
//   speed, last_row            : ticks per row (0 acts as 1), wrap row
//   row_req/row_addr           : row read request and address
//   row_valid/row_data         : row read response
//   freq_word, vol, note_trig  : voice controls
//   playing, cur_row           : status
//   tick_overrun               : sticky dropped-tick flag, cleared by start
module channel_sequencer #(
  parameter int PHASE_WIDTH    = 32,
  parameter int ROW_ADDR_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst_active_low,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      tick_strobe,
  input  logic [4:0]                speed,
  input  logic [ROW_ADDR_WIDTH-1:0] last_row,
  output logic                      row_req,
  output logic [ROW_ADDR_WIDTH-1:0] row_addr,
  input  logic                      row_valid,
  input  logic [31:0]               row_data,
  output logic [PHASE_WIDTH-1:0]    freq_word,
  output logic [5:0]                vol,
  output logic                      note_trig,
  output logic                      playing,
  output logic [ROW_ADDR_WIDTH-1:0] cur_row,
  output logic                      tick_overrun
);
  import channel_seq_pkg::*;

  function automatic logic [5:0] vol_slide_sat(input logic [5:0] cur, input logic [7:0] prm);
    logic signed [7:0] sum;
    sum = $signed({2'b00, cur}) + $signed({4'b0000, prm[7:4]}) - $signed({4'b0000, prm[3:0]});
    if (sum < 8'sd0)
      return 6'd0;
    else if (sum > $signed({2'b00, VOL_MAX}))
      return VOL_MAX;
    else
      return sum[5:0];
  endfunction

  seq_state_t                state, state_nxt;
  logic                      row_req_nxt, trig_nxt, ovr_nxt;
  logic [ROW_ADDR_WIDTH-1:0] row_addr_nxt, cur_row_nxt, adv_row;
  logic [PHASE_WIDTH-1:0]    freq_nxt, fcw_lookup;
  logic [5:0]                vol_nxt;
  logic [4:0]                tick_cnt, tick_cnt_nxt;
  logic                      tick_pending, pend_nxt;
  logic                      capture, latch_fx;

  logic [7:0]                note_p0;
  logic                      vv_p0;
  logic [5:0]                volume_p0;
  logic [7:0]                effect_p0, param_p0;
  logic [4:0]                speed_eff;
  logic [ROW_ADDR_WIDTH-1:0] last_eff;
  logic [7:0]                effect, param;

  logic unused_bits;
  assign unused_bits = row_data[22];

  note_to_fcw #(.PHASE_WIDTH(PHASE_WIDTH)) u_fcw (
    .note (note_p0),
    .fcw  (fcw_lookup)
  );

  assign adv_row = (cur_row == last_eff) ? '0 : cur_row + 1'b1;

  always_comb begin
    state_nxt    = state;
    row_req_nxt  = row_req;
    row_addr_nxt = row_addr;
    cur_row_nxt  = cur_row;
    freq_nxt     = freq_word;
    vol_nxt      = vol;
    trig_nxt     = 1'b0;
    ovr_nxt      = tick_overrun;
    tick_cnt_nxt = tick_cnt;
    pend_nxt     = tick_pending;
    capture      = 1'b0;
    latch_fx     = 1'b0;
    if (stop) begin
      state_nxt   = ST_IDLE;
      row_req_nxt = 1'b0;
      vol_nxt     = 6'd0;
      pend_nxt    = 1'b0;
    end else if (start) begin
      state_nxt    = ST_FETCH;
      row_req_nxt  = 1'b1;
      row_addr_nxt = '0;
      cur_row_nxt  = '0;
      tick_cnt_nxt = 5'd0;
      ovr_nxt      = 1'b0;
      pend_nxt     = 1'b0;
    end else begin
      // Ticks arriving while a row is in flight are held one deep.
      if ((state == ST_FETCH || state == ST_APPLY) && tick_strobe) begin
        if (tick_pending)
          ovr_nxt = 1'b1;
        else
          pend_nxt = 1'b1;
      end
      case (state)
        ST_FETCH: begin
          if (row_req && row_valid) begin
            capture     = 1'b1;
            row_req_nxt = 1'b0;
            state_nxt   = ST_APPLY;
          end
        end
        ST_APPLY: begin
          latch_fx = 1'b1;
          if (note_p0 != 8'd0 && note_p0 <= NOTE_MAX) begin
            freq_nxt = fcw_lookup;
            trig_nxt = 1'b1;
            vol_nxt  = vv_p0 ? volume_p0 : VOL_MAX;
          end else if (note_p0 == NOTE_OFF) begin
            vol_nxt = 6'd0;
          end else if (vv_p0) begin
            vol_nxt = volume_p0;
          end
          state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (tick_strobe || tick_pending) begin
            // A fresh strobe alongside a pending tick stays queued.
            pend_nxt = tick_pending && tick_strobe;
            if (tick_cnt == speed_eff - 5'd1) begin
              tick_cnt_nxt = 5'd0;
              cur_row_nxt  = adv_row;
              row_addr_nxt = adv_row;
              row_req_nxt  = 1'b1;
              state_nxt    = ST_FETCH;
            end else begin
              tick_cnt_nxt = tick_cnt + 5'd1;
              if (effect == EFF_VOL_SLIDE)
                vol_nxt = vol_slide_sat(vol, param);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_active_low) begin
    if (!rst_active_low) begin
      state        <= ST_IDLE;
      row_req      <= 1'b0;
      row_addr     <= '0;
      cur_row      <= '0;
      freq_word    <= '0;
      vol          <= 6'd0;
      note_trig    <= 1'b0;
      playing      <= 1'b0;
      tick_overrun <= 1'b0;
      tick_cnt     <= 5'd0;
      tick_pending <= 1'b0;
    end else begin
      state        <= state_nxt;
      row_req      <= row_req_nxt;
      row_addr     <= row_addr_nxt;
      cur_row      <= cur_row_nxt;
      freq_word    <= freq_nxt;
      vol          <= vol_nxt;
      note_trig    <= trig_nxt;
      playing      <= (state_nxt != ST_IDLE);
      tick_overrun <= ovr_nxt;
      tick_cnt     <= tick_cnt_nxt;
      tick_pending <= pend_nxt;
    end
  end

  // Stage p0: row fields and per-row settings captured on the fetch response
  always_ff @(posedge clk) begin
    if (capture) begin
      note_p0   <= row_data[NOTE_MSB:NOTE_LSB];
      vv_p0     <= row_data[VOL_VALID_BIT];
      volume_p0 <= row_data[VOLUME_MSB:VOLUME_LSB];
      effect_p0 <= row_data[EFFECT_MSB:EFFECT_LSB];
      param_p0  <= row_data[PARAM_MSB:PARAM_LSB];
      speed_eff <= (speed == 5'd0) ? 5'd1 : speed;
      last_eff  <= last_row;
    end
    // Stage p1: effect becomes active for the ticks of this row
    if (latch_fx) begin
      effect <= effect_p0;
      param  <= param_p0;
    end
  end

endmodule
